// File: rtl/display_rr_scheduler.sv
// Round-robin scheduler sharing one 4-digit select/decode path among four sources.
// Each grant lasts up to DWELL cycles and is always followed by a one-cycle blank gap.
module display_rr_scheduler #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic [3:0] an,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(DWELL - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic [3:0]      gnt_q, gnt_d;
  logic            done_q, done_d;

  logic            win_valid;
  logic [1:0]      win_idx;

  // Search starts one past the previous winner, wrapping mod 4.
  always_comb begin
    logic [1:0] cand;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    case (state_q)
      StGrant: begin
        if (!en) begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          done_d  = 1'b1;
        end else if (!req[sel_q] || (cnt_q == '0)) begin
          state_d = StGap;
          gnt_d   = 4'b0000;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // Idle and gap both arbitrate; sel holds its last value when nothing wins.
        if (en && win_valid) begin
          state_d = StGrant;
          sel_d   = win_idx;
          last_d  = win_idx;
          gnt_d   = 4'b0001 << win_idx;
          cnt_d   = CntLoad;
        end else begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign an   = ~gnt_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_display_rr_scheduler.sv
// Bench for display_rr_scheduler: directed scenarios then random traffic, two DWELL settings,
// each instance compared every cycle against a grant-owner model of the arbitration rules.
module tb_display_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [1:0] sel4, sel1;
  logic [3:0] gnt4, gnt1, an4, an1;
  logic       busy4, busy1, done4, done1;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 -> DWELL=4, index 1 -> DWELL=1.
  int dwell   [2] = '{4, 1};
  int m_owner [2];
  int m_used  [2];
  bit m_gap   [2];
  int m_last  [2];
  int m_sel   [2];
  bit m_done  [2];

  display_rr_scheduler #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .sel(sel4), .gnt(gnt4), .an(an4), .busy(busy4), .done(done4)
  );

  display_rr_scheduler #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .sel(sel1), .gnt(gnt1), .an(an1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_owner[j] = -1;
      m_used[j]  = 0;
      m_gap[j]   = 1'b0;
      m_last[j]  = 3;
      m_sel[j]   = 0;
      m_done[j]  = 1'b0;
    end
  endtask

  // One clock edge of the arbitration rules, using inputs held across the edge.
  task automatic model_tick();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int j = 0; j < 2; j++) begin
      m_done[j] = 1'b0;
      if (m_owner[j] >= 0) begin
        if (!en) begin
          m_owner[j] = -1;
          m_gap[j]   = 1'b0;
          m_done[j]  = 1'b1;
        end else if (!req[m_owner[j]] || m_used[j] >= dwell[j]) begin
          m_owner[j] = -1;
          m_gap[j]   = 1'b1;
          m_done[j]  = 1'b1;
        end else begin
          m_used[j]++;
        end
      end else begin
        m_gap[j] = 1'b0;
        if (en) begin
          for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last[j] + k) % 4;
            if (m_owner[j] < 0 && req[c]) begin
              m_owner[j] = c;
              m_last[j]  = c;
              m_sel[j]   = c;
              m_used[j]  = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int j = 0; j < 2; j++) begin
      logic [3:0] eg;
      logic [3:0] ag, aa, as, ab, ad;
      string      sfx;
      eg  = (m_owner[j] >= 0) ? (4'b0001 << m_owner[j]) : 4'b0000;
      sfx = (j == 0) ? "_d4" : "_d1";
      ag  = (j == 0) ? gnt4 : gnt1;
      aa  = (j == 0) ? an4 : an1;
      as  = (j == 0) ? {2'b00, sel4} : {2'b00, sel1};
      ab  = (j == 0) ? {3'b000, busy4} : {3'b000, busy1};
      ad  = (j == 0) ? {3'b000, done4} : {3'b000, done1};
      check({"gnt", sfx}, ag, eg);
      check({"an", sfx}, aa, ~eg);
      check({"sel", sfx}, as, 4'(m_sel[j]));
      check({"busy", sfx}, ab, {3'b000, (m_owner[j] >= 0) || m_gap[j]});
      check({"done", sfx}, ad, {3'b000, m_done[j]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    en  = 1'b1;
    req = 4'b0000;
    #1;
    check_all();
    run(2);
    rst_n = 1'b1;
    run(2);

    // Single requester: period DWELL+1
    req = 4'b0100;
    run(12);

    // Full rotation
    req = 4'b1111;
    run(22);

    // Early release of source 0 in its second cycle
    req = 4'b0000;
    run(3);
    req = 4'b0011;
    run(2);
    req = 4'b0010;
    run(8);

    // Enable drop during a grant to source 3, then re-enable
    req = 4'b0000;
    run(3);
    req = 4'b1000;
    run(2);
    en = 1'b0;
    run(1);
    check("sel_held_3", {2'b00, sel4}, 4'd3);
    run(2);
    req = 4'b1001;
    en  = 1'b1;
    run(1);
    check("reenable_gnt", gnt4, 4'b0001);
    run(6);

    // Alternating pair, interesting mainly for DWELL=1
    req = 4'b1010;
    run(10);

    // Asynchronous reset mid-grant, no clock edge
    req = 4'b1111;
    run(6);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run(2);
    rst_n = 1'b1;
    run(1);
    check("first_after_reset", gnt4, 4'b0001);

    // Random traffic; req changes occasionally so full-length grants still happen
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        rst_n = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
